rx_os_decoder: RTL and testbench
================================

Name: rx_os_decoder

Overview:
- Per-lane receive-side ordered-set decoder for Gen1/Gen2 (8b/10b symbol) operation.
- Sits between the PIPE RX data interface and the RX LTSSM. It is the receive counterpart of the TX ordered-set generator.
- Recognises TS1, TS2, SKP and EIOS ordered sets in the symbol stream and reports the decoded TS fields.
- Maintains a consecutive-identical-TS counter, which the LTSSM uses for its "N consecutive TS" exit rules.

Parameters:
- PIPEWIDTH, 8, PIPE RX data width in bits; legal values 8, 16, 32 (1, 2, 4 symbols per clock).
- CONSEC_W, 4, width of the consecutive-TS counter; the counter saturates at 2^CONSEC_W-1.

Ports:
- pclk  in  1  PIPE clock.
- reset_n  in  1  asynchronous active-low reset.
- RxData  in  PIPEWIDTH  received symbols; symbol 0 in bits [7:0], processed LSB symbol first.
- RxDataK  in  PIPEWIDTH/8  K flag per symbol.
- RxValid  in  1  cycle qualifier; when low, the cycle is ignored and all state is held.
- clear_count  in  1  synchronous clear of the consecutive-TS counter.
- os_valid  out  1  one-cycle pulse: an ordered set completed.
- os_type  out  3  0 none, 1 TS1, 2 TS2, 3 SKP, 4 EIOS, 5 FTS.
- os_link_num  out  8  TS symbol 1 value.
- os_link_pad  out  1  TS symbol 1 was PAD (K23.7).
- os_lane_num  out  8  TS symbol 2 value.
- os_lane_pad  out  1  TS symbol 2 was PAD.
- os_nfts  out  8  TS symbol 3.
- os_rate_id  out  8  TS symbol 4.
- os_train_ctrl  out  8  TS symbol 5.
- ts_consec_count  out  CONSEC_W  count of consecutive identical TS.
- os_error  out  1  one-cycle pulse: malformed ordered set.

Behaviour:
- Clock/reset: single clock pclk. Reset is asynchronous, active-low, on reset_n. All outputs reset to 0; FSM resets to HUNT; symbol index resets to 0.
- Symbol codes:
  - COM = K 0xBC; PAD = K 0xF7; SKP = K 0x1C; IDL = K 0x7C; FTS = K 0x3C.
  - TS1 identifier = D 0x4A; TS2 identifier = D 0x45.
- Symbols within a cycle are processed sequentially: symbol k+1 sees the state left by symbol k.
- FSM states:
  - HUNT: a COM sets index=1 and moves to HEAD. Any other symbol is dropped silently, with no error.
  - HEAD (index 1..5):
    - Index 1: K SKP → SKPB; K IDL → IDLB.
    - Index 1 and 2: PAD or any D symbol is accepted and stored; the pad flag is set when the symbol is PAD.
    - Index 3..5: D symbol stored.
    - After index 5 → IDENT.
  - IDENT (index 6..15):
    - Index 6 fixes the type: 0x4A → TS1, 0x45 → TS2.
    - Index 7..15 must equal the index-6 identifier.
    - Index 15 accepted → completion.
  - SKPB / IDLB: two further SKP (resp. IDL) symbols are required; the third completes the set as SKP (resp. EIOS).
- Violations (any state except HUNT) → os_error and return to HUNT. A violation is any of:
  - a K symbol where D is required;
  - a wrong identifier;
  - a non-SKP symbol in SKPB or a non-IDL symbol in IDLB;
  - a K other than PAD at index 1 or 2.
- COM inside an OS: counts as an error and also restarts the set (index=1, HEAD).
- Completion: the registered outputs update, and os_valid pulses, in the cycle after the cycle containing the final symbol.
  - TS fields hold their values until the next TS completion.
  - SKP and EIOS completions update only os_type.
- At most one completion is possible per cycle. os_error and os_valid may pulse in the same cycle.
- Consecutive-TS counter:
  - A TS completion whose type and symbols 1..5 (including pad flags) equal the previous TS → count+1, saturating.
  - Otherwise the count is set to 1.
  - SKP completion: no effect on the counter.
  - EIOS completion: counter cleared to 0.
  - clear_count: counter cleared to 0. It has priority over a same-cycle completion; the previous-TS record is still updated.
  - os_error: no effect on the counter.
- RxValid low mid-OS: state is held and decoding resumes on the next valid cycle.
- Reset mid-OS: the partial set is discarded.

Optional Feature:
- Macro: RX_OS_FTS_DETECT_EN.
- Defined: index-1 FTS → FTSB state; three FTS symbols complete the set with os_type=5. The counter is unaffected.
- Undefined: FTS at index 1 is a violation (os_error, HUNT), and os_type 5 never occurs.

Decomposition:
- Package rx_os_pkg holds:
  - the K/D symbol constants;
  - the os_type encoding;
  - the FSM state enum;
  - the TS field record typedef (link, lane, pads, nfts, rate, ctrl).
- Sub-module rx_os_symbol_step: combinational single-symbol next-state/field/complete/error logic.
  - Instantiated PIPEWIDTH/8 times and chained within the cycle.
  - The top module holds the registers and the counter.

Test Plan:
- 8 back-to-back TS1 (link 0x01, lane 0x00, nfts 0x10, rate 0x02, ctrl 0x00), PIPEWIDTH=32 → 8 os_valid pulses, each 4 cycles apart, os_type=1; ts_consec_count goes 1..8.
- TS1 with link=PAD and lane=PAD, then TS2 with the same fields → os_link_pad=1, os_lane_pad=1; count 1 then 1; os_type 1 then 2.
- SKP set (COM,SKP,SKP,SKP) inserted between two identical TS2; then EIOS → count 1 then 2, unaffected by SKP; EIOS completion clears count to 0; os_type 3 then 4.
- TS1 with symbol 9 = 0x45 → os_error pulse, no os_valid. A COM arriving at index 8 → os_error, and the following 15 symbols complete a valid TS.
- PIPEWIDTH=16: RxValid deasserted for 3 cycles mid-TS, reset_n asserted mid-TS in a second run → in the first run the TS completes correctly; in the second, all outputs read 0 and the partial set is discarded.
- clear_count asserted in the same cycle as the 4th identical TS completion → count=0, then the next identical TS gives count=1.

Source files
------------

// File: rtl/rx_os_pkg.sv
// rx_os_pkg: symbol codes, ordered-set type encoding, decoder FSM states and
// the TS field record shared by rx_os_decoder and rx_os_symbol_step.
package rx_os_pkg;

    // 8b/10b control (K) symbol codes
    localparam logic [7:0] KCom = 8'hBC;
    localparam logic [7:0] KPad = 8'hF7;
    localparam logic [7:0] KSkp = 8'h1C;
    localparam logic [7:0] KIdl = 8'h7C;
    localparam logic [7:0] KFts = 8'h3C;

    // TS identifier data (D) symbols
    localparam logic [7:0] DTs1 = 8'h4A;
    localparam logic [7:0] DTs2 = 8'h45;

    // Symbol index landmarks inside an ordered set
    localparam logic [3:0] IdxLastHead  = 4'd5;
    localparam logic [3:0] IdxIdent     = 4'd6;
    localparam logic [3:0] IdxLastIdent = 4'd15;
    localparam logic [3:0] IdxLastRun   = 4'd3;

    typedef enum logic [2:0] {
        OsNone = 3'd0,
        OsTs1  = 3'd1,
        OsTs2  = 3'd2,
        OsSkp  = 3'd3,
        OsEios = 3'd4,
        OsFts  = 3'd5
    } os_type_e;

    typedef enum logic [2:0] {
        StHunt  = 3'd0,
        StHead  = 3'd1,
        StIdent = 3'd2,
        StSkpb  = 3'd3,
        StIdlb  = 3'd4,
        StFtsb  = 3'd5
    } os_state_e;

    typedef struct packed {
        logic [7:0] link;
        logic       link_pad;
        logic [7:0] lane;
        logic       lane_pad;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] ctrl;
    } ts_fields_t;

    localparam int unsigned TsFieldsW = $bits(ts_fields_t);

    function automatic logic is_k_code(input logic k, input logic [7:0] d,
                                       input logic [7:0] code);
        return k && (d == code);
    endfunction

endpackage

// File: rtl/rx_os_symbol_step.sv
// rx_os_symbol_step: combinational decode of one received symbol. Takes the
// decoder state left by the previous symbol and produces the state seen by the
// next one, plus completion/error flags for this symbol.
// Optional FTS ordered-set detection is enabled by defining RX_OS_FTS_DETECT_EN.
module rx_os_symbol_step
    import rx_os_pkg::*;
(
    input  logic [7:0]           sym_i,
    input  logic                 sym_k_i,
    input  logic [2:0]           state_i,
    input  logic [3:0]           idx_i,
    input  logic [TsFieldsW-1:0] fields_i,
    input  logic [2:0]           ident_i,
    output logic [2:0]           state_o,
    output logic [3:0]           idx_o,
    output logic [TsFieldsW-1:0] fields_o,
    output logic [2:0]           ident_o,
    output logic                 complete_o,
    output logic [2:0]           comp_type_o,
    output logic                 error_o
);

    os_state_e  state_in;
    os_state_e  state_nx;
    ts_fields_t fld;
    logic [3:0] idx_nx;
    logic [2:0] ident_nx;
    logic [7:0] ident_byte;
    logic [7:0] run_code;
    os_type_e   run_type;
    logic       is_com;

    assign state_in   = os_state_e'(state_i);
    assign is_com     = is_k_code(sym_k_i, sym_i, KCom);
    assign ident_byte = (ident_i == OsTs1) ? DTs1 : DTs2;

    assign state_o  = state_nx;
    assign idx_o    = idx_nx;
    assign fields_o = fld;
    assign ident_o  = ident_nx;

    // Symbol expected and type reported by the repeated-K sets (SKP, EIOS, FTS)
    always_comb begin
        run_code = KSkp;
        run_type = OsSkp;
        case (state_in)
            StIdlb: begin
                run_code = KIdl;
                run_type = OsEios;
            end
            StFtsb: begin
                run_code = KFts;
                run_type = OsFts;
            end
            default: ;
        endcase
    end

    // Single-symbol FSM step: field capture, completion and violation detection
    always_comb begin
        state_nx    = state_in;
        idx_nx      = idx_i;
        fld         = ts_fields_t'(fields_i);
        ident_nx    = ident_i;
        complete_o  = 1'b0;
        comp_type_o = OsNone;
        error_o     = 1'b0;

        case (state_in)
            StHunt: begin
                if (is_com) begin
                    state_nx = StHead;
                    idx_nx   = 4'd1;
                end
            end

            StHead: begin
                if (is_com) begin
                    // COM mid-set is an error but also starts a fresh set
                    error_o  = 1'b1;
                    state_nx = StHead;
                    idx_nx   = 4'd1;
                end else if (idx_i == 4'd1 && is_k_code(sym_k_i, sym_i, KSkp)) begin
                    state_nx = StSkpb;
                    idx_nx   = 4'd2;
                end else if (idx_i == 4'd1 && is_k_code(sym_k_i, sym_i, KIdl)) begin
                    state_nx = StIdlb;
                    idx_nx   = 4'd2;
`ifdef RX_OS_FTS_DETECT_EN
                end else if (idx_i == 4'd1 && is_k_code(sym_k_i, sym_i, KFts)) begin
                    state_nx = StFtsb;
                    idx_nx   = 4'd2;
`endif
                end else if (sym_k_i && !(sym_i == KPad && idx_i <= 4'd2)) begin
                    error_o  = 1'b1;
                    state_nx = StHunt;
                    idx_nx   = 4'd0;
                end else begin
                    // Only PAD can reach here as a K symbol, so sym_k_i is the pad flag
                    case (idx_i)
                        4'd1: begin
                            fld.link     = sym_i;
                            fld.link_pad = sym_k_i;
                        end
                        4'd2: begin
                            fld.lane     = sym_i;
                            fld.lane_pad = sym_k_i;
                        end
                        4'd3:    fld.nfts = sym_i;
                        4'd4:    fld.rate = sym_i;
                        default: fld.ctrl = sym_i;
                    endcase
                    idx_nx = idx_i + 4'd1;
                    if (idx_i == IdxLastHead) begin
                        state_nx = StIdent;
                    end
                end
            end

            StIdent: begin
                if (is_com) begin
                    error_o  = 1'b1;
                    state_nx = StHead;
                    idx_nx   = 4'd1;
                end else if (sym_k_i) begin
                    error_o  = 1'b1;
                    state_nx = StHunt;
                    idx_nx   = 4'd0;
                end else if (idx_i == IdxIdent) begin
                    if (sym_i == DTs1) begin
                        ident_nx = OsTs1;
                        idx_nx   = idx_i + 4'd1;
                    end else if (sym_i == DTs2) begin
                        ident_nx = OsTs2;
                        idx_nx   = idx_i + 4'd1;
                    end else begin
                        error_o  = 1'b1;
                        state_nx = StHunt;
                        idx_nx   = 4'd0;
                    end
                end else if (sym_i != ident_byte) begin
                    error_o  = 1'b1;
                    state_nx = StHunt;
                    idx_nx   = 4'd0;
                end else if (idx_i == IdxLastIdent) begin
                    complete_o  = 1'b1;
                    comp_type_o = ident_i;
                    state_nx    = StHunt;
                    idx_nx      = 4'd0;
                end else begin
                    idx_nx = idx_i + 4'd1;
                end
            end

            StSkpb, StIdlb, StFtsb: begin
                if (is_com) begin
                    error_o  = 1'b1;
                    state_nx = StHead;
                    idx_nx   = 4'd1;
                end else if (is_k_code(sym_k_i, sym_i, run_code)) begin
                    if (idx_i == IdxLastRun) begin
                        complete_o  = 1'b1;
                        comp_type_o = run_type;
                        state_nx    = StHunt;
                        idx_nx      = 4'd0;
                    end else begin
                        idx_nx = idx_i + 4'd1;
                    end
                end else begin
                    error_o  = 1'b1;
                    state_nx = StHunt;
                    idx_nx   = 4'd0;
                end
            end

            default: begin
                state_nx = StHunt;
                idx_nx   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/rx_os_decoder.sv
// rx_os_decoder: per-lane Gen1/Gen2 receive ordered-set decoder. Chains one
// rx_os_symbol_step per symbol of the PIPE word, registers the decoded TS
// fields and maintains the consecutive-identical-TS counter for the LTSSM.
// Optional FTS detection: define RX_OS_FTS_DETECT_EN (see rx_os_symbol_step).
module rx_os_decoder
    import rx_os_pkg::*;
#(
    parameter int unsigned PIPEWIDTH = 8,
    parameter int unsigned CONSEC_W  = 4
) (
    input  logic                   pclk,
    input  logic                   reset_n,
    input  logic [PIPEWIDTH-1:0]   RxData,
    input  logic [PIPEWIDTH/8-1:0] RxDataK,
    input  logic                   RxValid,
    input  logic                   clear_count,
    output logic                   os_valid,
    output logic [2:0]             os_type,
    output logic [7:0]             os_link_num,
    output logic                   os_link_pad,
    output logic [7:0]             os_lane_num,
    output logic                   os_lane_pad,
    output logic [7:0]             os_nfts,
    output logic [7:0]             os_rate_id,
    output logic [7:0]             os_train_ctrl,
    output logic [CONSEC_W-1:0]    ts_consec_count,
    output logic                   os_error
);

    localparam int unsigned NumSym = PIPEWIDTH / 8;

    // Decoder working state carried between cycles
    logic [2:0]           state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [TsFieldsW-1:0] fld_q, fld_d;
    logic [2:0]           ident_q, ident_d;

    // Registered outputs and counter bookkeeping
    logic                 os_valid_q, os_valid_d;
    logic                 os_error_q, os_error_d;
    logic [2:0]           os_type_q, os_type_d;
    ts_fields_t           out_fld_q, out_fld_d;
    logic [CONSEC_W-1:0]  count_q, count_d;
    logic [TsFieldsW-1:0] prev_fld_q, prev_fld_d;
    logic [2:0]           prev_type_q, prev_type_d;
    logic                 prev_valid_q, prev_valid_d;

    // Per-symbol step results
    logic [NumSym-1:0]    comp_vec;
    logic [NumSym-1:0]    err_vec;
    logic [2:0]           comp_type_arr [NumSym];
    logic [TsFieldsW-1:0] comp_fld_arr  [NumSym];

    logic                 any_comp;
    logic [2:0]           sel_type;
    logic [TsFieldsW-1:0] sel_fld;
    logic                 ts_done;
    logic                 same_ts;

    for (genvar i = 0; i < NumSym; i++) begin : g_step
        logic [2:0]           st_in, st_out;
        logic [3:0]           idx_in, idx_out;
        logic [TsFieldsW-1:0] fld_in, fld_out;
        logic [2:0]           ident_in, ident_out;
        logic                 comp, err;
        logic [2:0]           ctype;

        if (i == 0) begin : g_first
            assign st_in    = state_q;
            assign idx_in   = idx_q;
            assign fld_in   = fld_q;
            assign ident_in = ident_q;
        end else begin : g_next
            assign st_in    = g_step[i-1].st_out;
            assign idx_in   = g_step[i-1].idx_out;
            assign fld_in   = g_step[i-1].fld_out;
            assign ident_in = g_step[i-1].ident_out;
        end

        rx_os_symbol_step u_step (
            .sym_i       (RxData[8*i +: 8]),
            .sym_k_i     (RxDataK[i]),
            .state_i     (st_in),
            .idx_i       (idx_in),
            .fields_i    (fld_in),
            .ident_i     (ident_in),
            .state_o     (st_out),
            .idx_o       (idx_out),
            .fields_o    (fld_out),
            .ident_o     (ident_out),
            .complete_o  (comp),
            .comp_type_o (ctype),
            .error_o     (err)
        );

        assign comp_vec[i]      = comp;
        assign err_vec[i]       = err;
        assign comp_type_arr[i] = ctype;
        // A completing symbol never alters the fields, so its output record is the set's
        assign comp_fld_arr[i]  = fld_out;
    end

    // Pick the completion in this word (at most one can occur per cycle)
    always_comb begin
        any_comp = 1'b0;
        sel_type = OsNone;
        sel_fld  = '0;
        for (int i = 0; i < NumSym; i++) begin
            if (comp_vec[i]) begin
                any_comp = 1'b1;
                sel_type = comp_type_arr[i];
                sel_fld  = comp_fld_arr[i];
            end
        end
    end

    assign ts_done = RxValid && any_comp && (sel_type == OsTs1 || sel_type == OsTs2);
    assign same_ts = prev_valid_q && (prev_type_q == sel_type) && (prev_fld_q == sel_fld);

    // Decoder state advances only on qualified cycles
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fld_d   = fld_q;
        ident_d = ident_q;
        if (RxValid) begin
            state_d = g_step[NumSym-1].st_out;
            idx_d   = g_step[NumSym-1].idx_out;
            fld_d   = g_step[NumSym-1].fld_out;
            ident_d = g_step[NumSym-1].ident_out;
        end
    end

    // Output registers, previous-TS record and consecutive-TS counter
    always_comb begin
        os_valid_d   = RxValid && any_comp;
        os_error_d   = RxValid && (|err_vec);
        os_type_d    = os_type_q;
        out_fld_d    = out_fld_q;
        count_d      = count_q;
        prev_fld_d   = prev_fld_q;
        prev_type_d  = prev_type_q;
        prev_valid_d = prev_valid_q;

        if (RxValid && any_comp) begin
            os_type_d = sel_type;
        end

        if (ts_done) begin
            out_fld_d    = ts_fields_t'(sel_fld);
            prev_fld_d   = sel_fld;
            prev_type_d  = sel_type;
            prev_valid_d = 1'b1;
            if (!same_ts) begin
                count_d = CONSEC_W'(1);
            end else if (!(&count_q)) begin
                count_d = count_q + CONSEC_W'(1);
            end
        end else if (RxValid && any_comp && sel_type == OsEios) begin
            count_d = '0;
        end

        // Clear wins over a same-cycle completion; the TS record above still updates
        if (clear_count) begin
            count_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StHunt;
            idx_q        <= '0;
            fld_q        <= '0;
            ident_q      <= OsNone;
            os_valid_q   <= 1'b0;
            os_error_q   <= 1'b0;
            os_type_q    <= OsNone;
            out_fld_q    <= '0;
            count_q      <= '0;
            prev_fld_q   <= '0;
            prev_type_q  <= OsNone;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fld_q        <= fld_d;
            ident_q      <= ident_d;
            os_valid_q   <= os_valid_d;
            os_error_q   <= os_error_d;
            os_type_q    <= os_type_d;
            out_fld_q    <= out_fld_d;
            count_q      <= count_d;
            prev_fld_q   <= prev_fld_d;
            prev_type_q  <= prev_type_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign os_valid        = os_valid_q;
    assign os_error        = os_error_q;
    assign os_type         = os_type_q;
    assign os_link_num     = out_fld_q.link;
    assign os_link_pad     = out_fld_q.link_pad;
    assign os_lane_num     = out_fld_q.lane;
    assign os_lane_pad     = out_fld_q.lane_pad;
    assign os_nfts         = out_fld_q.nfts;
    assign os_rate_id      = out_fld_q.rate;
    assign os_train_ctrl   = out_fld_q.ctrl;
    assign ts_consec_count = count_q;

endmodule

// File: tb/tb_rx_os_decoder.sv
// tb_rx_os_decoder: scoreboard bench for rx_os_decoder. One 32-bit and one
// 16-bit instance; expected output events are queued when stimulus is built
// and popped against events captured whenever os_valid or os_error pulses.
module tb_rx_os_decoder;

    localparam logic [7:0] KCom = 8'hBC;
    localparam logic [7:0] KPad = 8'hF7;
    localparam logic [7:0] KSkp = 8'h1C;
    localparam logic [7:0] KIdl = 8'h7C;
    localparam logic [7:0] DTs1 = 8'h4A;
    localparam logic [7:0] DTs2 = 8'h45;

    typedef struct packed {
        logic       k;
        logic [7:0] d;
    } sym_t;

    typedef struct packed {
        logic       v;
        logic       e;
        logic [2:0] t;
        logic [7:0] link;
        logic       lpad;
        logic [7:0] lane;
        logic       npad;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] ctrl;
        logic [3:0] cnt;
    } ev_t;

    logic pclk = 1'b0;
    logic reset_n;
    always #5 pclk = ~pclk;

    logic [31:0] a_data;
    logic [3:0]  a_k;
    logic        a_valid, a_clr;
    logic        a_os_valid, a_os_error, a_link_pad, a_lane_pad;
    logic [2:0]  a_os_type;
    logic [7:0]  a_link, a_lane, a_nfts, a_rate, a_ctrl;
    logic [3:0]  a_cnt;

    logic [15:0] b_data;
    logic [1:0]  b_k;
    logic        b_valid, b_clr;
    logic        b_os_valid, b_os_error, b_link_pad, b_lane_pad;
    logic [2:0]  b_os_type;
    logic [7:0]  b_link, b_lane, b_nfts, b_rate, b_ctrl;
    logic [3:0]  b_cnt;

    rx_os_decoder #(.PIPEWIDTH(32), .CONSEC_W(4)) dut_a (
        .pclk(pclk), .reset_n(reset_n), .RxData(a_data), .RxDataK(a_k), .RxValid(a_valid),
        .clear_count(a_clr), .os_valid(a_os_valid), .os_type(a_os_type),
        .os_link_num(a_link), .os_link_pad(a_link_pad), .os_lane_num(a_lane),
        .os_lane_pad(a_lane_pad), .os_nfts(a_nfts), .os_rate_id(a_rate),
        .os_train_ctrl(a_ctrl), .ts_consec_count(a_cnt), .os_error(a_os_error)
    );

    rx_os_decoder #(.PIPEWIDTH(16), .CONSEC_W(4)) dut_b (
        .pclk(pclk), .reset_n(reset_n), .RxData(b_data), .RxDataK(b_k), .RxValid(b_valid),
        .clear_count(b_clr), .os_valid(b_os_valid), .os_type(b_os_type),
        .os_link_num(b_link), .os_link_pad(b_link_pad), .os_lane_num(b_lane),
        .os_lane_pad(b_lane_pad), .os_nfts(b_nfts), .os_rate_id(b_rate),
        .os_train_ctrl(b_ctrl), .ts_consec_count(b_cnt), .os_error(b_os_error)
    );

    sym_t sym_a[$];
    sym_t sym_b[$];
    ev_t  obs_a[$];
    ev_t  obs_b[$];
    ev_t  exp_q[$];
    int   cyc_a[$];
    int   cyc_b[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic ev_t snap_a();
        ev_t r;
        r.v = a_os_valid; r.e = a_os_error; r.t = a_os_type;
        r.link = a_link; r.lpad = a_link_pad; r.lane = a_lane; r.npad = a_lane_pad;
        r.nfts = a_nfts; r.rate = a_rate; r.ctrl = a_ctrl; r.cnt = a_cnt;
        return r;
    endfunction

    function automatic ev_t snap_b();
        ev_t r;
        r.v = b_os_valid; r.e = b_os_error; r.t = b_os_type;
        r.link = b_link; r.lpad = b_link_pad; r.lane = b_lane; r.npad = b_lane_pad;
        r.nfts = b_nfts; r.rate = b_rate; r.ctrl = b_ctrl; r.cnt = b_cnt;
        return r;
    endfunction

    function automatic ev_t mk(input logic v, input logic e, input logic [2:0] t,
                               input logic [7:0] link, input logic lpad,
                               input logic [7:0] lane, input logic npad,
                               input logic [7:0] nfts, input logic [7:0] rate,
                               input logic [7:0] ctrl, input logic [3:0] cnt);
        ev_t r;
        r.v = v; r.e = e; r.t = t; r.link = link; r.lpad = lpad; r.lane = lane;
        r.npad = npad; r.nfts = nfts; r.rate = rate; r.ctrl = ctrl; r.cnt = cnt;
        return r;
    endfunction

    // One clock; inputs change 1 time unit after the edge, outputs sampled there too
    task automatic step();
        @(posedge pclk);
        #1;
        if (a_os_valid || a_os_error) begin
            obs_a.push_back(snap_a());
            cyc_a.push_back(cyc);
        end
        if (b_os_valid || b_os_error) begin
            obs_b.push_back(snap_b());
            cyc_b.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic push_ts(input bit to_b, input logic [7:0] id, input logic [7:0] link,
                           input bit lpad, input logic [7:0] lane, input bit npad,
                           input logic [7:0] nfts, input logic [7:0] rate,
                           input logic [7:0] ctrl);
        sym_t s [16];
        s[0] = {1'b1, KCom};
        s[1] = lpad ? {1'b1, KPad} : {1'b0, link};
        s[2] = npad ? {1'b1, KPad} : {1'b0, lane};
        s[3] = {1'b0, nfts};
        s[4] = {1'b0, rate};
        s[5] = {1'b0, ctrl};
        for (int i = 6; i < 16; i++) s[i] = {1'b0, id};
        for (int i = 0; i < 16; i++) begin
            if (to_b) sym_b.push_back(s[i]);
            else      sym_a.push_back(s[i]);
        end
    endtask

    task automatic push_run_a(input logic [7:0] code);
        sym_a.push_back({1'b1, KCom});
        for (int i = 0; i < 3; i++) sym_a.push_back({1'b1, code});
    endtask

    task automatic run_a(input int clr_cyc);
        int   n;
        sym_t s;
        n = (sym_a.size() + 3) / 4;
        for (int c = 0; c < n; c++) begin
            for (int j = 0; j < 4; j++) begin
                s = '0;
                if (sym_a.size() > 0) s = sym_a.pop_front();
                a_data[8*j +: 8] = s.d;
                a_k[j] = s.k;
            end
            a_clr = (c == clr_cyc);
            step();
        end
        a_data = '0; a_k = '0; a_clr = 1'b0;
        step();
        step();
    endtask

    task automatic run_b(input int n);
        sym_t s;
        for (int c = 0; c < n; c++) begin
            for (int j = 0; j < 2; j++) begin
                s = '0;
                if (sym_b.size() > 0) s = sym_b.pop_front();
                b_data[8*j +: 8] = s.d;
                b_k[j] = s.k;
            end
            step();
        end
        b_data = '0; b_k = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (snap_a() !== '0) begin
            failures++;
            $display("FAIL reset_a: got %h expected 0", snap_a());
        end
        checks++;
        if (snap_b() !== '0) begin
            failures++;
            $display("FAIL reset_b: got %h expected 0", snap_b());
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_ts1_burst();
        ev_t e, o;
        int  start;
        obs_a.delete(); cyc_a.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_ts(1'b0, DTs1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h10, 8'h02, 8'h00);
            exp_q.push_back(mk(1, 0, 3'd1, 8'h01, 0, 8'h00, 0, 8'h10, 8'h02, 8'h00, 4'(i + 1)));
        end
        start = cyc;
        run_a(-1);
        checks++;
        if (cyc_a.size() != 8) begin
            failures++;
            $display("FAIL burst_count: got %0d pulses expected 8", cyc_a.size());
        end else begin
            checks++;
            if (cyc_a[0] != start + 3) begin
                failures++;
                $display("FAIL burst_latency: got cycle %0d expected %0d", cyc_a[0], start + 3);
            end
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (cyc_a[i] - cyc_a[i-1] != 4) begin
                    failures++;
                    $display("FAIL burst_spacing %0d: got %0d expected 4", i,
                             cyc_a[i] - cyc_a[i-1]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++;
                $display("FAIL burst_event: got none expected %h", e);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL burst_event: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_ts_pad();
        ev_t e, o;
        obs_a.delete(); exp_q.delete();
        push_ts(1'b0, DTs1, 8'h00, 1'b1, 8'h00, 1'b1, 8'h10, 8'h02, 8'h00);
        push_ts(1'b0, DTs2, 8'h00, 1'b1, 8'h00, 1'b1, 8'h10, 8'h02, 8'h00);
        exp_q.push_back(mk(1, 0, 3'd1, KPad, 1, KPad, 1, 8'h10, 8'h02, 8'h00, 4'd1));
        exp_q.push_back(mk(1, 0, 3'd2, KPad, 1, KPad, 1, 8'h10, 8'h02, 8'h00, 4'd1));
        run_a(-1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++;
                $display("FAIL pad_event: got none expected %h", e);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL pad_event: got %h expected %h", o, e);
                end
            end
        end
        checks++;
        if (obs_a.size() != 0) begin
            failures++;
            $display("FAIL pad_extra: got %0d events expected 0", obs_a.size());
        end
    endtask

    task automatic test_skp_eios();
        ev_t e, o;
        obs_a.delete(); exp_q.delete();
        push_ts(1'b0, DTs2, 8'h05, 1'b0, 8'h01, 1'b0, 8'h10, 8'h02, 8'h00);
        push_run_a(KSkp);
        push_ts(1'b0, DTs2, 8'h05, 1'b0, 8'h01, 1'b0, 8'h10, 8'h02, 8'h00);
        push_run_a(KIdl);
        exp_q.push_back(mk(1, 0, 3'd2, 8'h05, 0, 8'h01, 0, 8'h10, 8'h02, 8'h00, 4'd1));
        exp_q.push_back(mk(1, 0, 3'd3, 8'h05, 0, 8'h01, 0, 8'h10, 8'h02, 8'h00, 4'd1));
        exp_q.push_back(mk(1, 0, 3'd2, 8'h05, 0, 8'h01, 0, 8'h10, 8'h02, 8'h00, 4'd2));
        exp_q.push_back(mk(1, 0, 3'd4, 8'h05, 0, 8'h01, 0, 8'h10, 8'h02, 8'h00, 4'd0));
        run_a(-1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++;
                $display("FAIL skp_eios_event: got none expected %h", e);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL skp_eios_event: got %h expected %h", o, e);
                end
            end
        end
        checks++;
        if (obs_a.size() != 0) begin
            failures++;
            $display("FAIL skp_eios_extra: got %0d events expected 0", obs_a.size());
        end
    endtask

    task automatic test_errors();
        ev_t  e, o;
        sym_t s;
        int   idx;
        obs_a.delete(); exp_q.delete();
        // Frame with a TS2 identifier in symbol 9 of a TS1
        push_ts(1'b0, DTs1, 8'h02, 1'b0, 8'h03, 1'b0, 8'h20, 8'h02, 8'h01);
        idx = sym_a.size() - 7;
        s = sym_a[idx];
        s.d = DTs2;
        sym_a[idx] = s;
        // Truncated frame: COM + symbols 1..7, then a full TS whose COM lands at index 8
        push_ts(1'b0, DTs1, 8'h02, 1'b0, 8'h03, 1'b0, 8'h20, 8'h02, 8'h01);
        for (int i = 0; i < 8; i++) void'(sym_a.pop_back());
        push_ts(1'b0, DTs1, 8'h02, 1'b0, 8'h03, 1'b0, 8'h20, 8'h02, 8'h01);
        exp_q.push_back(mk(0, 1, 3'd4, 8'h05, 0, 8'h01, 0, 8'h10, 8'h02, 8'h00, 4'd0));
        exp_q.push_back(mk(0, 1, 3'd4, 8'h05, 0, 8'h01, 0, 8'h10, 8'h02, 8'h00, 4'd0));
        exp_q.push_back(mk(1, 0, 3'd1, 8'h02, 0, 8'h03, 0, 8'h20, 8'h02, 8'h01, 4'd1));
        run_a(-1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++;
                $display("FAIL error_event: got none expected %h", e);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL error_event: got %h expected %h", o, e);
                end
            end
        end
        checks++;
        if (obs_a.size() != 0) begin
            failures++;
            $display("FAIL error_extra: got %0d events expected 0", obs_a.size());
        end
    endtask

    task automatic test_clear_count();
        ev_t        e, o;
        logic [3:0] exp_cnt [5];
        obs_a.delete(); exp_q.delete();
        exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd3;
        exp_cnt[3] = 4'd0; exp_cnt[4] = 4'd1;
        for (int i = 0; i < 5; i++) begin
            push_ts(1'b0, DTs1, 8'h07, 1'b0, 8'h02, 1'b0, 8'h30, 8'h02, 8'h00);
            exp_q.push_back(mk(1, 0, 3'd1, 8'h07, 0, 8'h02, 0, 8'h30, 8'h02, 8'h00,
                               exp_cnt[i]));
        end
        // Cycle 15 carries the final symbol of the 4th TS
        run_a(15);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                failures++;
                $display("FAIL clear_event: got none expected %h", e);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL clear_event: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_rxvalid_gap();
        ev_t e, o;
        int  start;
        obs_b.delete(); cyc_b.delete(); exp_q.delete();
        push_ts(1'b1, DTs1, 8'h0A, 1'b0, 8'h01, 1'b0, 8'h08, 8'h02, 8'h00);
        exp_q.push_back(mk(1, 0, 3'd1, 8'h0A, 0, 8'h01, 0, 8'h08, 8'h02, 8'h00, 4'd1));
        start = cyc;
        run_b(4);
        // Garbage (COMs) while RxValid is low must be ignored
        b_valid = 1'b0;
        b_data = {KCom, KCom};
        b_k = 2'b11;
        for (int i = 0; i < 3; i++) step();
        b_valid = 1'b1;
        run_b(4);
        step();
        step();
        checks++;
        if (cyc_b.size() != 1 || cyc_b[0] != start + 10) begin
            failures++;
            $display("FAIL gap_latency: got %0d pulses first at %0d expected 1 at %0d",
                     cyc_b.size(), (cyc_b.size() > 0) ? cyc_b[0] : -1, start + 10);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_b.size() == 0) begin
                failures++;
                $display("FAIL gap_event: got none expected %h", e);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL gap_event: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_b.delete(); cyc_b.delete();
        push_ts(1'b1, DTs1, 8'h0A, 1'b0, 8'h01, 1'b0, 8'h08, 8'h02, 8'h00);
        run_b(4);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (snap_b() !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h expected 0", snap_b());
        end
        step();
        step();
        reset_n = 1'b1;
        run_b(4);
        step();
        step();
        checks++;
        if (obs_b.size() != 0) begin
            failures++;
            $display("FAIL reset_discard: got %0d events expected 0", obs_b.size());
        end
        checks++;
        if (snap_b() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", snap_b());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_data = '0; a_k = '0; a_valid = 1'b1; a_clr = 1'b0;
        b_data = '0; b_k = '0; b_valid = 1'b1; b_clr = 1'b0;
        test_reset();
        test_ts1_burst();
        test_ts_pad();
        test_skp_eios();
        test_errors();
        test_clear_count();
        test_rxvalid_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
